bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_CLIENTS, default 4: number of clients, legal range 2..8.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: data width in bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4: address width in bits.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 15: maximum number of cycles to wait for srv_ack.
REQ-005 SHALL use one clock and an asynchronous, active-high reset:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have the following client-side ports:
- rq  in  NUM_CLIENTS  per-client request.
- address  in  NUM_CLIENTS*ADDR_WIDTH  per-client address; client i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- wr_ni  in  NUM_CLIENTS  per-client operation select: 1 = read, 0 = write.
- dataW  in  NUM_CLIENTS*DATA_WIDTH  per-client write data; sliced the same way as address.
- ack  out  NUM_CLIENTS  per-client one-cycle completion pulse.
- dataR  out  DATA_WIDTH  read data, common to all clients, valid while any ack bit is high.
- err  out  1  timeout flag, valid while any ack bit is high.
REQ-007 SHALL have the following server-side ports:
- srv_rq  out  1  server request, held high for the whole transfer.
- srv_address  out  ADDR_WIDTH  latched address of the granted client.
- srv_wr_ni  out  1  latched operation select of the granted client.
- srv_dataW  out  DATA_WIDTH  latched write data of the granted client.
- srv_ack  in  1  server completion.
- srv_dataR  in  DATA_WIDTH  server read data, sampled together with srv_ack.
REQ-008 SHALL have the following status ports:
- grant_id  out  3  index of the granted client.
- busy  out  1  high in every state except IDLE.

Function
REQ-009 SHALL implement the FSM IDLE -> BUSY -> ACK -> IDLE.
REQ-010 IDLE: when any unmasked rq bit is high at an edge, SHALL select a winner by round-robin, latch the winner's address/wr_ni/dataW and its index, and enter BUSY on that edge.
REQ-011 Round-robin SHALL search upward from last_grant+1 with wrap-around at NUM_CLIENTS-1 -> 0; last_grant updates only when a grant is made.
REQ-012 BUSY: srv_rq=1 and srv_* outputs SHALL be driven from the latched registers; the latched values SHALL stay stable for the whole of BUSY even if the client's inputs change.
REQ-013 BUSY with srv_ack=1 at an edge: SHALL latch srv_dataR into dataR, clear err, and enter ACK.
REQ-014 BUSY timeout: the wait counter SHALL be 0 on BUSY entry and increment each BUSY cycle; when it reaches TIMEOUT_CYCLES without srv_ack, SHALL set dataR=0 and err=1 and enter ACK.
REQ-015 If srv_ack=1 arrives on the same edge as the timeout, srv_ack SHALL take priority (err=0).
REQ-016 ACK: ack[grant_id]=1 and srv_rq=0 for exactly one cycle; all other ack bits 0; SHALL return to IDLE on the next edge.
REQ-017 The client just acknowledged SHALL be masked from arbitration during the first IDLE cycle after ACK; other clients are unaffected.
REQ-018 rq edges arriving while busy=1 SHALL NOT be lost; a held rq is served on a later IDLE cycle.
REQ-019 Latency: rq sampled at edge t -> srv_rq high from t+1; srv_ack sampled at edge u -> ack high in cycle u+1; minimum request-to-ack time is 3 cycles.
REQ-020 srv_ack sampled in IDLE or ACK SHALL be ignored.
REQ-021 The timeout counter SHALL be sized to hold TIMEOUT_CYCLES and SHALL NOT wrap.

Reset
REQ-022 Reset SHALL put the FSM in IDLE with last_grant=NUM_CLIENTS-1, so that client 0 wins first.
REQ-023 Reset SHALL drive ack=0, srv_rq=0, busy=0, err=0, dataR=0, srv_address=0, srv_wr_ni=0, srv_dataW=0, grant_id=0, and clear the mask and the timeout counter.
REQ-024 Reset asserted mid-transfer SHALL abort the transfer immediately, with no ack pulse and srv_rq=0.

Structure
REQ-025 Package bus_arb_pkg SHALL hold the FSM state encoding (IDLE/BUSY/ACK) and the default parameter constants.
REQ-026 A sub-module rr_picker SHALL hold the combinational round-robin search: inputs req vector and last_grant; outputs valid and winner index.

Verification
REQ-027 After reset, rq=4'b1111 with server ack after 2 cycles -> grants go to clients 0,1,2,3,0 in that order.
REQ-028 Client 2 read at address 4'h5, server returns 8'hA7 with srv_ack -> ack[2] one cycle with dataR=8'hA7, err=0; srv_address=4'h5 and srv_wr_ni=1 for the whole of BUSY.
REQ-029 srv_ack never asserted -> ack pulse after TIMEOUT_CYCLES=15 BUSY cycles with err=1, dataR=0.
REQ-030 srv_ack on the exact timeout cycle -> err=0 and dataR equals srv_dataR.
REQ-031 Client 1 keeps rq high one cycle after ack while client 3 is requesting -> client 3 is granted next and client 1 gets no duplicate grant.
REQ-032 Reset pulsed in the middle of BUSY -> srv_rq=0 immediately, no ack, and the next grant goes to client 0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter.
// Holds the FSM state encoding, the default parameter constants and a small
// helper that turns a client index into a one-hot vector.
package bus_arb_pkg;

    localparam int DEF_NUM_CLIENTS    = 4;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_ADDR_WIDTH     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 15;

    // Client indices are carried on 3 bits so up to 8 clients fit.
    localparam int GRANT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } arb_state_t;

    // One-hot decode of a client index; callers slice off the bits they need.
    function automatic logic [7:0] idx_to_onehot(input logic [GRANT_W-1:0] idx);
        logic [7:0] oh;
        oh = 8'd0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search.
// Ports:
//   req        in   NUM_CLIENTS  request vector (already masked by the caller)
//   last_grant in   3            index of the most recent grant
//   valid      out  1            at least one request present
//   winner     out  3            first requesting index above last_grant, wrapping
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = DEF_NUM_CLIENTS
) (
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic [GRANT_W-1:0]     last_grant,
    output logic                   valid,
    output logic [GRANT_W-1:0]     winner
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    logic [IDX_W-1:0] cand_s;

    // Walk the clients starting just after last_grant; the last offset
    // revisits last_grant itself so a lone requester can still win.
    always_comb begin
        valid  = 1'b0;
        winner = {GRANT_W{1'b0}};
        cand_s = {IDX_W{1'b0}};
        for (int off = 1; off <= NUM_CLIENTS; off++) begin
            cand_s = IDX_W'((int'(last_grant) + off) % NUM_CLIENTS);
            if (!valid && req[cand_s]) begin
                valid  = 1'b1;
                winner = GRANT_W'(cand_s);
            end else begin
                valid  = valid;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one server among NUM_CLIENTS clients.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   rq/address/wr_ni/dataW     per-client request, address, op (1=read), write data
//   ack/dataR/err              per-client completion pulse, read data, timeout flag
//   srv_rq/srv_address/srv_wr_ni/srv_dataW  latched request towards the server
//   srv_ack/srv_dataR          server completion and read data
//   grant_id/busy              granted client index, FSM not in IDLE
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_CLIENTS    = DEF_NUM_CLIENTS,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            rq,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address,
    input  logic [NUM_CLIENTS-1:0]            wr_ni,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW,
    output logic [NUM_CLIENTS-1:0]            ack,
    output logic [DATA_WIDTH-1:0]             dataR,
    output logic                              err,
    output logic                              srv_rq,
    output logic [ADDR_WIDTH-1:0]             srv_address,
    output logic                              srv_wr_ni,
    output logic [DATA_WIDTH-1:0]             srv_dataW,
    input  logic                              srv_ack,
    input  logic [DATA_WIDTH-1:0]             srv_dataR,
    output logic [2:0]                        grant_id,
    output logic                              busy
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // The counter starts at 0 on BUSY entry, so the value seen in the
    // TIMEOUT_CYCLES-th BUSY cycle is TIMEOUT_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t               state_r;
    logic [GRANT_W-1:0]       last_grant_r;
    logic [NUM_CLIENTS-1:0]   mask_r;
    logic [CNT_W-1:0]         wait_cnt_r;
    logic [GRANT_W-1:0]       grant_id_r;
    logic [ADDR_WIDTH-1:0]    srv_address_r;
    logic                     srv_wr_ni_r;
    logic [DATA_WIDTH-1:0]    srv_dataW_r;
    logic                     srv_rq_r;
    logic [NUM_CLIENTS-1:0]   ack_r;
    logic [DATA_WIDTH-1:0]    dataR_r;
    logic                     err_r;
    logic                     busy_r;

    logic [NUM_CLIENTS-1:0]   req_masked_s;
    logic                     pick_valid_s;
    logic [GRANT_W-1:0]       pick_winner_s;
    logic [ADDR_WIDTH-1:0]    sel_addr_s;
    logic                     sel_wr_ni_s;
    logic [DATA_WIDTH-1:0]    sel_dataW_s;
    logic [7:0]               grant_oh_s;
    logic [7:0]               winner_oh_s;

    assign req_masked_s = rq & ~mask_r;
    assign grant_oh_s   = idx_to_onehot(grant_id_r);
    assign winner_oh_s  = idx_to_onehot(pick_winner_s);

    rr_picker #(
        .NUM_CLIENTS (NUM_CLIENTS)
    ) u_rr_picker (
        .req        (req_masked_s),
        .last_grant (last_grant_r),
        .valid      (pick_valid_s),
        .winner     (pick_winner_s)
    );

    // AND-OR mux of the winning client's address, op and write data.
    always_comb begin
        sel_addr_s  = {ADDR_WIDTH{1'b0}};
        sel_wr_ni_s = 1'b0;
        sel_dataW_s = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            sel_addr_s  = sel_addr_s  | (address[i*ADDR_WIDTH +: ADDR_WIDTH] & {ADDR_WIDTH{winner_oh_s[i]}});
            sel_wr_ni_s = sel_wr_ni_s | (wr_ni[i] & winner_oh_s[i]);
            sel_dataW_s = sel_dataW_s | (dataW[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{winner_oh_s[i]}});
        end
    end

    // Arbiter FSM with all outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            last_grant_r  <= GRANT_W'(NUM_CLIENTS - 1);
            mask_r        <= {NUM_CLIENTS{1'b0}};
            wait_cnt_r    <= {CNT_W{1'b0}};
            grant_id_r    <= {GRANT_W{1'b0}};
            srv_address_r <= {ADDR_WIDTH{1'b0}};
            srv_wr_ni_r   <= 1'b0;
            srv_dataW_r   <= {DATA_WIDTH{1'b0}};
            srv_rq_r      <= 1'b0;
            ack_r         <= {NUM_CLIENTS{1'b0}};
            dataR_r       <= {DATA_WIDTH{1'b0}};
            err_r         <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r  <= {NUM_CLIENTS{1'b0}};
                    // The post-ACK mask only lives for this one IDLE cycle.
                    mask_r <= {NUM_CLIENTS{1'b0}};
                    if (pick_valid_s) begin
                        grant_id_r    <= pick_winner_s;
                        last_grant_r  <= pick_winner_s;
                        srv_address_r <= sel_addr_s;
                        srv_wr_ni_r   <= sel_wr_ni_s;
                        srv_dataW_r   <= sel_dataW_s;
                        wait_cnt_r    <= {CNT_W{1'b0}};
                        srv_rq_r      <= 1'b1;
                        busy_r        <= 1'b1;
                        state_r       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // A server ack wins over a timeout on the same edge.
                    if (srv_ack) begin
                        dataR_r  <= srv_dataR;
                        err_r    <= 1'b0;
                        ack_r    <= grant_oh_s[NUM_CLIENTS-1:0];
                        srv_rq_r <= 1'b0;
                        state_r  <= ST_ACK;
                    end else if (wait_cnt_r == CNT_LAST) begin
                        dataR_r  <= {DATA_WIDTH{1'b0}};
                        err_r    <= 1'b1;
                        ack_r    <= grant_oh_s[NUM_CLIENTS-1:0];
                        srv_rq_r <= 1'b0;
                        state_r  <= ST_ACK;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                ST_ACK: begin
                    ack_r   <= {NUM_CLIENTS{1'b0}};
                    mask_r  <= grant_oh_s[NUM_CLIENTS-1:0];
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    ack_r    <= {NUM_CLIENTS{1'b0}};
                    srv_rq_r <= 1'b0;
                    busy_r   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    assign ack         = ack_r;
    assign dataR       = dataR_r;
    assign err         = err_r;
    assign srv_rq      = srv_rq_r;
    assign srv_address = srv_address_r;
    assign srv_wr_ni   = srv_wr_ni_r;
    assign srv_dataW   = srv_dataW_r;
    assign grant_id    = grant_id_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter with default parameters.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rq = 4'd0;
    logic [15:0] address = 16'd0;
    logic [3:0]  wr_ni = 4'd0;
    logic [31:0] dataW = 32'd0;
    logic [3:0]  ack;
    logic [7:0]  dataR;
    logic        err;
    logic        srv_rq;
    logic [3:0]  srv_address;
    logic        srv_wr_ni;
    logic [7:0]  srv_dataW;
    logic        srv_ack = 1'b0;
    logic [7:0]  srv_dataR = 8'd0;
    logic [2:0]  grant_id;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0] id;
        logic [3:0] addr;
        logic       wr;
        logic [7:0] dw;
    } grant_t;

    typedef struct packed {
        logic [3:0] ackv;
        logic [7:0] data;
        logic       err;
    } ack_t;

    grant_t gq[$];
    ack_t   aq[$];
    logic   srv_rq_q = 1'b0;

    bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .rq          (rq),
        .address     (address),
        .wr_ni       (wr_ni),
        .dataW       (dataW),
        .ack         (ack),
        .dataR       (dataR),
        .err         (err),
        .srv_rq      (srv_rq),
        .srv_address (srv_address),
        .srv_wr_ni   (srv_wr_ni),
        .srv_dataW   (srv_dataW),
        .srv_ack     (srv_ack),
        .srv_dataR   (srv_dataR),
        .grant_id    (grant_id),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare each new grant and each ack pulse against the queues.
    always @(negedge clk) begin
        grant_t g;
        ack_t   a;
        if (srv_rq === 1'b1 && srv_rq_q !== 1'b1) begin
            if (gq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant: actual grant_id=%0d required=none", grant_id);
            end else begin
                g = gq.pop_front();
                check("grant_id", 32'(grant_id), 32'(g.id));
                check("grant_addr", 32'(srv_address), 32'(g.addr));
                check("grant_wr_ni", 32'(srv_wr_ni), 32'(g.wr));
                check("grant_dataW", 32'(srv_dataW), 32'(g.dw));
            end
        end
        if (ack !== 4'd0) begin
            if (aq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: actual ack=%0h required=none", ack);
            end else begin
                a = aq.pop_front();
                check("ack_vec", 32'(ack), 32'(a.ackv));
                check("ack_dataR", 32'(dataR), 32'(a.data));
                check("ack_err", 32'(err), 32'(a.err));
            end
        end
        srv_rq_q <= srv_rq;
    end

    task automatic wait_srv_rq();
        int n = 0;
        while (srv_rq !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("srv_rq_arrives", 32'(srv_rq), 32'd1);
    endtask

    // Hold srv_ack off for n_wait-1 BUSY cycles, pulse it in BUSY cycle n_wait.
    task automatic serve(input int n_wait, input logic [7:0] d,
                         input logic [3:0] ea, input logic ew);
        repeat (n_wait - 1) begin
            check("busy_addr_stable", 32'(srv_address), 32'(ea));
            check("busy_wr_stable", 32'(srv_wr_ni), 32'(ew));
            @(negedge clk);
        end
        check("busy_srv_rq", 32'(srv_rq), 32'd1);
        srv_dataR = d;
        srv_ack   = 1'b1;
        @(negedge clk);
        srv_ack = 1'b0;
        check("ack_cycle_srv_rq", 32'(srv_rq), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_srv_rq"}, 32'(srv_rq), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_dataR"}, 32'(dataR), 32'd0);
        check({tag, "_srv_addr"}, 32'(srv_address), 32'd0);
        check({tag, "_srv_wr"}, 32'(srv_wr_ni), 32'd0);
        check({tag, "_srv_dataW"}, 32'(srv_dataW), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order[5];
        int n;
        order = '{0, 1, 2, 3, 0};

        // Reset state, during and just after reset.
        repeat (3) @(negedge clk);
        check_idle_outputs("in_reset");
        reset = 1'b0;
        @(negedge clk);
        check_idle_outputs("post_reset");

        // Everyone requests: grants 0,1,2,3,0.
        address = 16'h4321;
        dataW   = 32'hD3D2D1D0;
        wr_ni   = 4'b0000;
        for (int j = 0; j < 5; j++)
            gq.push_back('{3'(order[j]), 4'(order[j] + 1), 1'b0, 8'(8'hD0 + order[j])});
        rq = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_srv_rq();
            aq.push_back('{4'(4'd1 << order[j]), 8'(8'hB0 + j), 1'b0});
            serve(2, 8'(8'hB0 + j), 4'(order[j] + 1), 1'b0);
            if (j == 4) rq = 4'b0000;
        end
        repeat (2) @(negedge clk);

        // Client 2 read at 5, inputs disturbed during BUSY.
        address[11:8]  = 4'h5;
        wr_ni[2]       = 1'b1;
        dataW[23:16]   = 8'h77;
        gq.push_back('{3'd2, 4'h5, 1'b1, 8'h77});
        rq = 4'b0100;
        wait_srv_rq();
        address[11:8] = 4'hF;
        wr_ni[2]      = 1'b0;
        dataW[23:16]  = 8'h88;
        aq.push_back('{4'b0100, 8'hA7, 1'b0});
        serve(3, 8'hA7, 4'h5, 1'b1);
        rq = 4'b0000;
        @(negedge clk);
        check("ack_one_cycle", 32'(ack), 32'd0);
        repeat (2) @(negedge clk);

        // Timeout: no server ack for client 0.
        address[3:0] = 4'h9;
        dataW[7:0]   = 8'h5E;
        srv_dataR    = 8'h3C;
        gq.push_back('{3'd0, 4'h9, 1'b0, 8'h5E});
        rq = 4'b0001;
        wait_srv_rq();
        aq.push_back('{4'b0001, 8'h00, 1'b1});
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (ack !== 4'd0) break;
            if (srv_rq === 1'b1) n++;
            @(negedge clk);
        end
        check("timeout_busy_cycles", 32'(n), 32'd15);
        rq = 4'b0000;
        repeat (2) @(negedge clk);

        // Server ack on the exact timeout cycle: ack wins.
        address[7:4] = 4'h6;
        dataW[15:8]  = 8'h61;
        gq.push_back('{3'd1, 4'h6, 1'b0, 8'h61});
        rq = 4'b0010;
        wait_srv_rq();
        aq.push_back('{4'b0010, 8'h5A, 1'b0});
        serve(15, 8'h5A, 4'h6, 1'b0);
        rq = 4'b0000;
        repeat (2) @(negedge clk);

        // Client 1 holds rq past its ack while client 3 waits.
        gq.push_back('{3'd1, 4'h6, 1'b0, 8'h61});
        rq = 4'b0010;
        wait_srv_rq();
        address[15:12] = 4'hC;
        dataW[31:24]   = 8'hC3;
        rq[3] = 1'b1;
        gq.push_back('{3'd3, 4'hC, 1'b0, 8'hC3});
        aq.push_back('{4'b0010, 8'h11, 1'b0});
        serve(2, 8'h11, 4'h6, 1'b0);
        @(negedge clk);
        rq[1] = 1'b0;
        wait_srv_rq();
        aq.push_back('{4'b1000, 8'h33, 1'b0});
        serve(1, 8'h33, 4'hC, 1'b0);
        rq = 4'b0000;
        repeat (2) @(negedge clk);

        // Lone client holding rq into the first IDLE cycle is masked there.
        gq.push_back('{3'd0, 4'h9, 1'b0, 8'h5E});
        rq = 4'b0001;
        wait_srv_rq();
        aq.push_back('{4'b0001, 8'h22, 1'b0});
        serve(1, 8'h22, 4'h9, 1'b0);
        @(negedge clk);
        rq = 4'b0000;
        repeat (3) @(negedge clk);
        check("mask_no_regrant_srv_rq", 32'(srv_rq), 32'd0);
        check("mask_no_regrant_busy", 32'(busy), 32'd0);

        // Reset in the middle of BUSY.
        address[11:8] = 4'h2;
        gq.push_back('{3'd2, 4'h2, 1'b0, 8'h88});
        rq = 4'b0100;
        wait_srv_rq();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_srv_rq", 32'(srv_rq), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ack", 32'(ack), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        gq.push_back('{3'd0, 4'h9, 1'b0, 8'h5E});
        rq = 4'b1111;
        wait_srv_rq();
        aq.push_back('{4'b0001, 8'h44, 1'b0});
        serve(1, 8'h44, 4'h9, 1'b0);
        rq = 4'b0000;
        repeat (3) @(negedge clk);

        check("queues_drained", 32'(gq.size() + aq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
